// File: rtl/msgpass_buff_wr_ctrl.sv
// Write-side front end for the dual-port message-passing buffer.
// Two request streams (A, B) are turned into the buffer's registered,
// active-low write ports. Both ports never target one address in the same
// cycle: a same-address pair is either serialized (A, then B one cycle
// later) or merged (B only). Each such event bumps a saturating counter.
//
// Handshake: a request is taken on a rising edge where valid && ready.
// The requester holds valid, addr and data stable until that edge. Ready is
// combinational and is low while rst_i is high.

package msgPass_config_pkg;
  localparam int MSGPASS_BUFF_ADDR_WIDTH  = 8;
  localparam int MSGPASS_BUFF_RDATA_WIDTH = 32;
endpackage

module msgpass_buff_wr_ctrl #(
  parameter int ADDR_WIDTH      = msgPass_config_pkg::MSGPASS_BUFF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = msgPass_config_pkg::MSGPASS_BUFF_RDATA_WIDTH,
  parameter int MERGE_SAME_ADDR = 0,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  write_clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_portA_i,
  input  logic                  req_valid_portB_i,
  output logic                  req_ready_portA_o,
  output logic                  req_ready_portB_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_portA_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_portB_i,
  input  logic [DATA_WIDTH-1:0] req_data_portA_i,
  input  logic [DATA_WIDTH-1:0] req_data_portB_i,
  output logic [ADDR_WIDTH-1:0] waddr_portA_o,
  output logic [ADDR_WIDTH-1:0] waddr_portB_o,
  output logic [DATA_WIDTH-1:0] wdata_portA_o,
  output logic [DATA_WIDTH-1:0] wdata_portB_o,
  output logic                  wen_portA_o,
  output logic                  wen_portB_o,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o,
  output logic                  busy_o
);

  localparam bit MERGE_EN = (MERGE_SAME_ADDR != 0);

  // Deferred port-B write (only used when same-address pairs are serialized).
  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_data;

  logic                  ready_a;
  logic                  ready_b;
  logic                  acc_a;
  logic                  acc_b;
  logic                  same_addr;
  logic                  issue_a;
  logic                  defer_b;

  logic [ADDR_WIDTH-1:0] waddr_a;
  logic [ADDR_WIDTH-1:0] waddr_b;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  wen_a;
  logic                  wen_b;
  logic [CNT_WIDTH-1:0]  conflict_cnt;

  // Acceptance and routing decisions for the upcoming edge. While a deferred
  // B is waiting, B is held off and an A to the same address is stalled one
  // cycle so it lands after the deferred B.
  always_comb begin
    ready_a   = !rst_i && !(pend_valid && req_valid_portA_i &&
                            (req_addr_portA_i == pend_addr));
    ready_b   = !rst_i && !pend_valid;
    acc_a     = req_valid_portA_i && ready_a;
    acc_b     = req_valid_portB_i && ready_b;
    same_addr = acc_a && acc_b && (req_addr_portA_i == req_addr_portB_i);
    issue_a   = acc_a && !(same_addr && MERGE_EN);
    defer_b   = same_addr && !MERGE_EN;
  end

  // Registered write ports plus the single-entry deferral register.
  always_ff @(posedge write_clk_i) begin
    if (rst_i) begin
      wen_a      <= 1'b1;
      wen_b      <= 1'b1;
      waddr_a    <= '0;
      waddr_b    <= '0;
      wdata_a    <= '0;
      wdata_b    <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      wen_a <= 1'b1;
      wen_b <= 1'b1;
      if (issue_a) begin
        wen_a   <= 1'b0;
        waddr_a <= req_addr_portA_i;
        wdata_a <= req_data_portA_i;
      end
      if (pend_valid) begin
        wen_b   <= 1'b0;
        waddr_b <= pend_addr;
        wdata_b <= pend_data;
      end else if (acc_b && !defer_b) begin
        wen_b   <= 1'b0;
        waddr_b <= req_addr_portB_i;
        wdata_b <= req_data_portB_i;
      end
      pend_valid <= defer_b;
      if (defer_b) begin
        pend_addr <= req_addr_portB_i;
        pend_data <= req_data_portB_i;
      end
    end
  end

  // Saturating count of same-address pairs; sticks at all-ones.
  always_ff @(posedge write_clk_i) begin
    if (rst_i) begin
      conflict_cnt <= '0;
    end else if (same_addr && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  assign req_ready_portA_o = ready_a;
  assign req_ready_portB_o = ready_b;
  assign waddr_portA_o     = waddr_a;
  assign waddr_portB_o     = waddr_b;
  assign wdata_portA_o     = wdata_a;
  assign wdata_portB_o     = wdata_b;
  assign wen_portA_o       = wen_a;
  assign wen_portB_o       = wen_b;
  assign conflict_cnt_o    = conflict_cnt;
  assign busy_o            = pend_valid;

endmodule

// File: doc/msgpass_buff_wr_ctrl.md
Name: msgpass_buff_wr_ctrl

Overview:
Write-side front end for the dual-port message-passing buffer. Accepts two independent write request streams (A, B) with valid/ready handshakes and drives the buffer's registered, active-LOW write ports. Guarantees that both buffer write ports never target the same address in the same cycle, which the buffer does not resolve itself. Same-address pairs are either serialized or merged, and each occurrence is counted.

Parameters:
ADDR_WIDTH, msgPass_config_pkg::MSGPASS_BUFF_ADDR_WIDTH, write address width
DATA_WIDTH, msgPass_config_pkg::MSGPASS_BUFF_RDATA_WIDTH, write data width
MERGE_SAME_ADDR, 0, 0: serialize same-address pair (A then B); 1: drop A, issue only B (B wins)
CNT_WIDTH, 16, width of saturating conflict counter

Ports:
write_clk_i  in  1  single clock; same clock as the buffer's write_clk_i
rst_i  in  1  synchronous reset, active-high
req_valid_portA_i / req_valid_portB_i  in  1 each  request valid
req_ready_portA_o / req_ready_portB_o  out  1 each  request ready (combinational)
req_addr_portA_i / req_addr_portB_i  in  ADDR_WIDTH each  write address
req_data_portA_i / req_data_portB_i  in  DATA_WIDTH each  write data
waddr_portA_o / waddr_portB_o  out  ADDR_WIDTH each  to buffer waddr
wdata_portA_o / wdata_portB_o  out  DATA_WIDTH each  to buffer wdata
wen_portA_o / wen_portB_o  out  1 each  to buffer wen, active LOW
conflict_cnt_o  out  CNT_WIDTH  same-address events seen, saturating
busy_o  out  1  1 while a deferred B write is pending

Behaviour:
- Reset (rst_i=1 at an edge): wen_*_o=1, waddr/wdata outputs=0, pending register cleared, conflict_cnt_o=0, busy_o=0.
- While rst_i=1, req_ready_*_o=0 combinationally.
- Handshake: a request is accepted on an edge where valid&&ready=1. Valid must hold with stable addr/data until accepted.
- Latency: a request accepted at edge N drives its wen low for exactly cycle N+1 with registered addr/data. A deferred B drives wen low in cycle N+2. With no acceptance, wen=1.
- Internal state: pend_valid, pend_addr, pend_data. busy_o=pend_valid.
- Case pend_valid=0:
  - ready_A=1, ready_B=1.
  - Both accepted, addresses differ: A goes to port A and B goes to port B, both at N+1.
  - Both accepted, same address, MERGE_SAME_ADDR=0: A goes to port A at N+1. B is loaded into pend and issues on port B at N+2. conflict_cnt increments.
  - Both accepted, same address, MERGE_SAME_ADDR=1: port A is idle at N+1. B goes to port B at N+1. conflict_cnt increments. pend is unused.
  - Single acceptance: issued on its own port at N+1.
- Case pend_valid=1:
  - Port B issues pend at the next edge, and pend clears.
  - ready_B=0.
  - ready_A = !(req_valid_portA_i && req_addr_portA_i==pend_addr). This stalls a same-address A for one cycle, preserving order and the no-conflict rule.
  - An accepted A issues on port A in the same output cycle as pend.
- Invariant: never both wen_*_o=0 with waddr_portA_o==waddr_portB_o.
- Write order per address: the later-accepted request lands later or in the same cycle on a different address, so the final memory content equals sequential A-before-B semantics.
- conflict_cnt saturates at all-ones and never wraps.
- Reset mid-operation: a pending B is discarded and not written. Outputs return to reset values at that edge.

Test Plan:
- Reset: hold rst_i 2 cycles with both valids=1 -> ready=0, wen_A=wen_B=1, conflict_cnt_o=0 throughout.
- Disjoint pair: A(addr 5, data 0xAA), B(addr 9, data 0xBB) same cycle -> next cycle wen_A=wen_B=0, waddr A/B = 5/9, data 0xAA/0xBB; cnt stays 0.
- Same address, MERGE=0: A(7, 0x11), B(7, 0x22) -> cycle+1: port A writes 7/0x11, wen_B=1, busy_o=1. cycle+2: port B writes 7/0x22. cnt=1. Buffer write_port_conflict_o never asserts.
- Stall on pending: after the previous step, new A(7, 0x33) presented while busy -> ready_A=0 for that cycle. Accepted the next cycle and written one cycle later.
- Same address, MERGE=1: A(3, 0x44), B(3, 0x55) -> single write on port B 3/0x55, wen_A=1, cnt=1.
- Saturation and reset mid-op: CNT_WIDTH=2, 5 conflicts -> cnt=3. Assert rst_i while busy_o=1 -> no port B write occurs next cycle, cnt=0.
